pipeline_hazard_ctrl: RTL
=========================

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 Parameter MDU_LAT, default 32, meaning total EX-freeze cycles for a mul/div op; legal range 2..255.
REQ-002 Parameter REG_AW, default 5, meaning register-address width.
REQ-003 clk  input  1  single clock; all state updates on posedge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 mem_wait  input  1  data memory not ready; freezes the whole pipeline.
REQ-006 mdu_start  input  1  mul/div op in EX requests multi-cycle execution.
REQ-007 br_taken  input  1  branch/jump in EX resolved taken.
REQ-008 idex_memread  input  1  instruction in ID/EX is a load.
REQ-009 idex_rt, ifid_rs, ifid_rt  input  REG_AW each  register numbers for load-use check.
REQ-010 pc_wr, ifid_wr, idex_wr, exmem_wr, memwb_wr  output  1 each  write enables for PC and the four pipeline registers.
REQ-011 ifid_flush, idex_flush, exmem_flush  output  1 each  load a bubble (zero) into that register at the next edge; only asserted together with its wr=1.
REQ-012 mdu_done  output  1  one-cycle pulse when the MDU freeze releases.
REQ-013 stall_cnt  output  32  count of cycles with pc_wr=0.

Function
REQ-014 FSM states: RUN, MDU_WAIT; 8-bit down-counter cnt.
REQ-015 load_use = idex_memread & (idex_rt != 0) & (idex_rt == ifid_rs | idex_rt == ifid_rt); combinational.
REQ-016 Priority, highest first: mem_wait, MDU freeze, br_taken, load_use, normal.
REQ-017 mem_wait=1 (any state): all five wr=0, all flush=0, mdu_done=0; FSM, cnt and br/load decisions hold.
REQ-018 MDU freeze = (RUN & mdu_start) or (MDU_WAIT & cnt != 0): pc_wr=ifid_wr=idex_wr=0, exmem_wr=1 with exmem_flush=1, memwb_wr=1.
REQ-019 RUN & mdu_start & !mem_wait: next state MDU_WAIT, cnt <= MDU_LAT-1.
REQ-020 MDU_WAIT & !mem_wait & cnt != 0: cnt decrements by 1.
REQ-021 MDU_WAIT & cnt == 0 & !mem_wait: mdu_done=1, outputs as RUN (br_taken/load_use honored), next state RUN; total frozen cycles = MDU_LAT.
REQ-022 br_taken (no higher-priority condition): all wr=1, ifid_flush=1, idex_flush=1; load_use ignored that cycle.
REQ-023 load_use (no higher-priority condition): pc_wr=0, ifid_wr=0, idex_wr=1 with idex_flush=1, exmem_wr=memwb_wr=1; one bubble per hazard.
REQ-024 Normal: all wr=1, all flush=0.
REQ-025 mdu_start is ignored while in MDU_WAIT.
REQ-026 All outputs except stall_cnt are combinational from state, cnt and inputs; no added latency.

Reset
REQ-027 rst_n=0: state RUN, cnt=0, stall_cnt=0 immediately, independent of clk.
REQ-028 While rst_n=0: all wr=0, all flush=0, mdu_done=0.
REQ-029 Reset during MDU_WAIT aborts the op; first cycle after release is RUN with no mdu_done.

Configuration
REQ-030 Macro HAZARD_STALL_CNT_EN defined: stall_cnt increments each posedge where rst_n=1 and pc_wr=0, saturating at 32'hFFFF_FFFF.
REQ-031 Macro undefined: stall_cnt port still present, tied to 0, no counter logic.

Verification
REQ-032 MDU_LAT=4, mdu_start 1 cycle in RUN -> pc_wr=0 for exactly 4 cycles, exmem_flush=1 those cycles, mdu_done=1 on the 5th.
REQ-033 idex_memread=1, idex_rt=5, ifid_rs=5 -> one cycle pc_wr=0, ifid_wr=0, idex_flush=1; idex_rt=0 with ifid_rs=0 -> no stall.
REQ-034 br_taken=1 with load_use=1 -> ifid_flush=idex_flush=1, pc_wr=1, no stall.
REQ-035 mem_wait=1 for 3 cycles in the 2nd MDU_WAIT cycle -> all wr=0 for 3 cycles, cnt frozen, mdu_done delayed by exactly 3 cycles.
REQ-036 rst_n low mid-MDU_WAIT -> outputs all 0 asynchronously; after release state RUN, stall_cnt=0, no mdu_done.
REQ-037 HAZARD_STALL_CNT_EN defined, MDU_LAT=4 op plus one load-use -> stall_cnt=5; undefined -> stall_cnt=0.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: stall/flush/freeze control for a 5-stage pipeline with a multi-cycle MDU.
// Optional stall-cycle counter enabled by defining HAZARD_STALL_CNT_EN.
module pipeline_hazard_ctrl #(
  parameter int MDU_LAT = 32,
  parameter int REG_AW  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_wait,
  input  logic              mdu_start,
  input  logic              br_taken,
  input  logic              idex_memread,
  input  logic [REG_AW-1:0] idex_rt,
  input  logic [REG_AW-1:0] ifid_rs,
  input  logic [REG_AW-1:0] ifid_rt,
  output logic              pc_wr,
  output logic              ifid_wr,
  output logic              idex_wr,
  output logic              exmem_wr,
  output logic              memwb_wr,
  output logic              ifid_flush,
  output logic              idex_flush,
  output logic              exmem_flush,
  output logic              mdu_done,
  output logic [31:0]       stall_cnt
);

  localparam logic [0:0] RUN      = 1'b0;
  localparam logic [0:0] MDU_WAIT = 1'b1;
  localparam logic [7:0] CNT_LOAD = 8'(MDU_LAT - 1);

  logic [0:0] state, state_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic       load_use;
  logic       mdu_freeze;

  assign load_use = idex_memread & (idex_rt != '0) &
                    ((idex_rt == ifid_rs) | (idex_rt == ifid_rt));

  // mdu_start only launches an op from RUN; it is ignored while waiting
  assign mdu_freeze = ((state == RUN) & mdu_start) | ((state == MDU_WAIT) & (cnt != 8'd0));

  always_comb begin
    pc_wr       = 1'b0;
    ifid_wr     = 1'b0;
    idex_wr     = 1'b0;
    exmem_wr    = 1'b0;
    memwb_wr    = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    mdu_done    = 1'b0;
    state_nxt   = state;
    cnt_nxt     = cnt;
    if (!rst_n || mem_wait) begin
      // whole pipeline held; FSM and counter hold their values
    end else if (mdu_freeze) begin
      exmem_wr    = 1'b1;
      exmem_flush = 1'b1;
      memwb_wr    = 1'b1;
      if (state == RUN) begin
        state_nxt = MDU_WAIT;
        cnt_nxt   = CNT_LOAD;
      end else begin
        cnt_nxt = cnt - 8'd1;
      end
    end else begin
      if (state == MDU_WAIT) begin
        mdu_done  = 1'b1;
        state_nxt = RUN;
      end
      if (br_taken) begin
        pc_wr      = 1'b1;
        ifid_wr    = 1'b1;
        idex_wr    = 1'b1;
        exmem_wr   = 1'b1;
        memwb_wr   = 1'b1;
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end else if (load_use) begin
        idex_wr    = 1'b1;
        idex_flush = 1'b1;
        exmem_wr   = 1'b1;
        memwb_wr   = 1'b1;
      end else begin
        pc_wr    = 1'b1;
        ifid_wr  = 1'b1;
        idex_wr  = 1'b1;
        exmem_wr = 1'b1;
        memwb_wr = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      cnt   <= 8'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

`ifdef HAZARD_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= 32'd0;
    end else if (!pc_wr && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`else
  assign stall_cnt = 32'd0;
`endif

endmodule
